// File: rtl/arc_pkg.sv
// Shared types and constants for the ARC MIPS pipeline front end.
//   addr_t / instr_t : 32-bit address and instruction words
//   fetch_state_t    : fetch-unit request FSM encoding
//   RESET_PC_DEF     : default fetch address after reset
//   NOP_INSTR_DEF    : default bubble word (sll $0,$0,0)
package arc_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] instr_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

  localparam addr_t  RESET_PC_DEF  = 32'h0000_0000;
  localparam instr_t NOP_INSTR_DEF = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline stage register (used here as IF/ID).
//   clk_i, rst_i      : clock, async active-high reset
//   we_i              : load instr_i/pcadd4_i/valid_i (highest priority after reset)
//   flush_i, stall_i  : when not written, flush loads a bubble, stall holds,
//                       otherwise a bubble is loaded
//   instr_o, pcadd4_o, valid_o : registered stage contents
module if_id_reg
  import arc_pkg::*;
#(
  parameter instr_t NOP = NOP_INSTR_DEF
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   we_i,
  input  logic   stall_i,
  input  logic   flush_i,
  input  instr_t instr_i,
  input  addr_t  pcadd4_i,
  input  logic   valid_i,
  output instr_t instr_o,
  output addr_t  pcadd4_o,
  output logic   valid_o
);

  instr_t instr_q;
  addr_t  pcadd4_q;
  logic   valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q  <= NOP;
      pcadd4_q <= '0;
      valid_q  <= 1'b0;
    end else if (we_i) begin
      instr_q  <= instr_i;
      pcadd4_q <= pcadd4_i;
      valid_q  <= valid_i;
    end else if (stall_i && !flush_i) begin
      instr_q  <= instr_q;
      pcadd4_q <= pcadd4_q;
      valid_q  <= valid_q;
    end else begin
      // flush, or an empty cycle with no stall: insert a bubble
      instr_q  <= NOP;
      pcadd4_q <= '0;
      valid_q  <= 1'b0;
    end
  end

  assign instr_o  = instr_q;
  assign pcadd4_o = pcadd4_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: fetch PC, instruction-memory request handshake, IF/ID register.
//   i_clk, i_rst                 : clock, async active-high reset
//   i_addr_nextpc, i_con_pcsrc   : next PC from selector, redirect taken
//   i_con_stallF/stallD/flushD   : hazard-unit controls
//   o_imem_req/addr, i_imem_ack/rdata : memory request/response
//   o_addr_pcF, o_addr_pcadd4    : fetch PC and PC+4 (combinational)
//   o_data_instrD, o_addr_pcadd4D, o_con_validD : IF/ID contents
//
// state  | meaning
// S_IDLE | no request outstanding; launches a fetch unless stalled/redirected
// S_WAIT | request outstanding, response still wanted
// S_DROP | request outstanding but redirected; response will be discarded
// S_HOLD | response captured while D stalled; waiting to load IF/ID
module if_fetch_stage
  import arc_pkg::*;
#(
  parameter addr_t  RESET_PC  = RESET_PC_DEF,
  parameter instr_t NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  addr_t  i_addr_nextpc,
  input  logic   i_con_pcsrc,
  input  logic   i_con_stallF,
  input  logic   i_con_stallD,
  input  logic   i_con_flushD,
  output logic   o_imem_req,
  output addr_t  o_imem_addr,
  input  logic   i_imem_ack,
  input  instr_t i_imem_rdata,
  output addr_t  o_addr_pcF,
  output addr_t  o_addr_pcadd4,
  output instr_t o_data_instrD,
  output addr_t  o_addr_pcadd4D,
  output logic   o_con_validD
);

  fetch_state_t state_q;
  addr_t        pc_q;
  logic         req_q;
  addr_t        imem_addr_q;
  instr_t       hold_instr_q;
  addr_t        hold_pcadd4_q;

  logic   kill;
  logic   wr_en;
  instr_t wr_instr;
  addr_t  wr_pcadd4;

  // A redirect or flush throws away whatever this fetch would deliver.
  assign kill = i_con_pcsrc | i_con_flushD;

  always_comb begin
    wr_en     = 1'b0;
    wr_instr  = i_imem_rdata;
    wr_pcadd4 = imem_addr_q + 32'd4;
    case (state_q)
      S_WAIT: wr_en = i_imem_ack && !kill && !i_con_stallD;
      S_HOLD: begin
        wr_en     = !kill && !i_con_stallD;
        wr_instr  = hold_instr_q;
        wr_pcadd4 = hold_pcadd4_q;
      end
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      req_q         <= 1'b0;
      imem_addr_q   <= '0;
      hold_instr_q  <= '0;
      hold_pcadd4_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_con_pcsrc) begin
            pc_q <= i_addr_nextpc;
          end else if (!i_con_stallF) begin
            req_q       <= 1'b1;
            imem_addr_q <= pc_q;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_imem_ack) begin
            req_q <= 1'b0;
            if (kill) begin
              if (i_con_pcsrc) pc_q <= i_addr_nextpc;
              state_q <= S_IDLE;
            end else if (!i_con_stallD) begin
              pc_q    <= i_addr_nextpc;
              state_q <= S_IDLE;
            end else begin
              hold_instr_q  <= i_imem_rdata;
              hold_pcadd4_q <= imem_addr_q + 32'd4;
              state_q       <= S_HOLD;
            end
          end else if (i_con_pcsrc) begin
            // request must stay up until acked; remember to drop its data
            pc_q    <= i_addr_nextpc;
            state_q <= S_DROP;
          end
        end
        S_DROP: begin
          if (i_con_pcsrc) pc_q <= i_addr_nextpc;
          if (i_imem_ack) begin
            req_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (kill) begin
            if (i_con_pcsrc) pc_q <= i_addr_nextpc;
            state_q <= S_IDLE;
          end else if (!i_con_stallD) begin
            pc_q    <= i_addr_nextpc;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
    .clk_i    (i_clk),
    .rst_i    (i_rst),
    .we_i     (wr_en),
    .stall_i  (i_con_stallD),
    .flush_i  (i_con_flushD),
    .instr_i  (wr_instr),
    .pcadd4_i (wr_pcadd4),
    .valid_i  (1'b1),
    .instr_o  (o_data_instrD),
    .pcadd4_o (o_addr_pcadd4D),
    .valid_o  (o_con_validD)
  );

  assign o_imem_req    = req_q;
  assign o_imem_addr   = imem_addr_q;
  assign o_addr_pcF    = pc_q;
  assign o_addr_pcadd4 = pc_q + 32'd4;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; the next-PC selector is modelled here.
module tb_if_fetch_stage;
  import arc_pkg::*;

  logic   i_clk = 1'b0;
  logic   i_rst;
  addr_t  i_addr_nextpc;
  logic   i_con_pcsrc, i_con_stallF, i_con_stallD, i_con_flushD;
  logic   o_imem_req;
  addr_t  o_imem_addr;
  logic   i_imem_ack;
  instr_t i_imem_rdata;
  addr_t  o_addr_pcF, o_addr_pcadd4, o_addr_pcadd4D;
  instr_t o_data_instrD;
  logic   o_con_validD;
  addr_t  tgt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 i_clk = ~i_clk;

  assign i_addr_nextpc = i_con_pcsrc ? tgt : o_addr_pcadd4;

  if_fetch_stage dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_addr_nextpc  (i_addr_nextpc),
    .i_con_pcsrc    (i_con_pcsrc),
    .i_con_stallF   (i_con_stallF),
    .i_con_stallD   (i_con_stallD),
    .i_con_flushD   (i_con_flushD),
    .o_imem_req     (o_imem_req),
    .o_imem_addr    (o_imem_addr),
    .i_imem_ack     (i_imem_ack),
    .i_imem_rdata   (i_imem_rdata),
    .o_addr_pcF     (o_addr_pcF),
    .o_addr_pcadd4  (o_addr_pcadd4),
    .o_data_instrD  (o_data_instrD),
    .o_addr_pcadd4D (o_addr_pcadd4D),
    .o_con_validD   (o_con_validD)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1; i_con_pcsrc = 0; i_con_stallF = 0; i_con_stallD = 0;
    i_con_flushD = 0; i_imem_ack = 0; i_imem_rdata = '0; tgt = '0;
    tick(); tick();
    chk("rst_pcF", o_addr_pcF, 32'h0);
    chk("rst_req", {31'b0, o_imem_req}, 32'h0);
    chk("rst_validD", {31'b0, o_con_validD}, 32'h0);
    chk("rst_instrD", o_data_instrD, 32'h0);
    i_rst = 1'b0;

    // request launched one cycle after release, held with stable address
    tick();
    chk("req_up", {31'b0, o_imem_req}, 32'h1);
    chk("req_addr", o_imem_addr, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("req_held", {31'b0, o_imem_req}, 32'h1);
      chk("addr_held", o_imem_addr, 32'h0);
    end

    // zero-wait ack
    i_imem_ack = 1; i_imem_rdata = 32'h2008_0005;
    tick();
    chk("zw_instrD", o_data_instrD, 32'h2008_0005);
    chk("zw_pcadd4D", o_addr_pcadd4D, 32'h4);
    chk("zw_validD", {31'b0, o_con_validD}, 32'h1);
    chk("zw_pcF", o_addr_pcF, 32'h4);
    chk("zw_req_low", {31'b0, o_imem_req}, 32'h0);
    i_imem_ack = 0;
    tick();
    chk("zw_req2", {31'b0, o_imem_req}, 32'h1);
    chk("zw_addr2", o_imem_addr, 32'h4);
    chk("zw_bubble", {31'b0, o_con_validD}, 32'h0);

    // ack while D stalled
    i_con_stallD = 1; i_imem_ack = 1; i_imem_rdata = 32'hAAAA_0001;
    tick();
    i_imem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_req", {31'b0, o_imem_req}, 32'h0);
      chk("st_validD", {31'b0, o_con_validD}, 32'h0);
      chk("st_pcF", o_addr_pcF, 32'h4);
    end
    i_con_stallD = 0;
    tick();
    chk("st_instrD", o_data_instrD, 32'hAAAA_0001);
    chk("st_pcadd4D", o_addr_pcadd4D, 32'h8);
    chk("st_validD1", {31'b0, o_con_validD}, 32'h1);
    chk("st_pcF8", o_addr_pcF, 32'h8);
    tick();
    chk("st_req8", {31'b0, o_imem_req}, 32'h1);
    chk("st_addr8", o_imem_addr, 32'h8);

    // redirect while waiting; late data must be dropped
    i_con_pcsrc = 1; tgt = 32'h100;
    tick();
    i_con_pcsrc = 0;
    chk("rd_pcF", o_addr_pcF, 32'h100);
    chk("rd_req", {31'b0, o_imem_req}, 32'h1);
    chk("rd_addr", o_imem_addr, 32'h8);
    tick();
    i_imem_ack = 1; i_imem_rdata = 32'hDEAD_BEEF;
    tick();
    i_imem_ack = 0;
    chk("rd_validD", {31'b0, o_con_validD}, 32'h0);
    chk("rd_instrD", o_data_instrD, 32'h0);
    chk("rd_pcF2", o_addr_pcF, 32'h100);
    tick();
    chk("rd_req2", {31'b0, o_imem_req}, 32'h1);
    chk("rd_addr2", o_imem_addr, 32'h100);

    // flush overrides stall
    i_imem_ack = 1; i_imem_rdata = 32'h1234_5678;
    tick();
    i_imem_ack = 0;
    chk("fl_pre_instr", o_data_instrD, 32'h1234_5678);
    chk("fl_pre_valid", {31'b0, o_con_validD}, 32'h1);
    chk("fl_pre_pc4D", o_addr_pcadd4D, 32'h104);
    i_con_stallD = 1; i_con_flushD = 1; i_con_stallF = 1;
    tick();
    chk("fl_instrD", o_data_instrD, 32'h0);
    chk("fl_validD", {31'b0, o_con_validD}, 32'h0);
    chk("fl_pc4D", o_addr_pcadd4D, 32'h0);
    chk("fl_noreq", {31'b0, o_imem_req}, 32'h0);
    i_con_stallD = 0; i_con_flushD = 0; i_con_stallF = 0;

    // async reset in the middle of a request
    tick();
    chk("ar_req", {31'b0, o_imem_req}, 32'h1);
    chk("ar_addr", o_imem_addr, 32'h104);
    #2;
    i_rst = 1'b1;
    #1;
    chk("ar_req0", {31'b0, o_imem_req}, 32'h0);
    chk("ar_pcF0", o_addr_pcF, 32'h0);
    chk("ar_addr0", o_imem_addr, 32'h0);
    i_imem_ack = 1; i_imem_rdata = 32'hBAD0_BAD0;
    tick(); tick();
    chk("ar_ackign", {31'b0, o_con_validD}, 32'h0);
    chk("ar_reqstill0", {31'b0, o_imem_req}, 32'h0);
    i_imem_ack = 0; i_rst = 1'b0;
    tick();
    chk("ar_restart_req", {31'b0, o_imem_req}, 32'h1);
    chk("ar_restart_addr", o_imem_addr, 32'h0);

    // PC wrap-around at top of address space
    i_con_pcsrc = 1; tgt = 32'hFFFF_FFFC;
    tick();
    i_con_pcsrc = 0;
    chk("wr_pcF", o_addr_pcF, 32'hFFFF_FFFC);
    chk("wr_pcadd4", o_addr_pcadd4, 32'h0);
    i_imem_ack = 1;
    tick();
    i_imem_ack = 0;
    tick();
    chk("wr_addr", o_imem_addr, 32'hFFFF_FFFC);
    i_imem_ack = 1; i_imem_rdata = 32'h0000_0001;
    tick();
    i_imem_ack = 0;
    chk("wr_pcadd4D", o_addr_pcadd4D, 32'h0);
    chk("wr_pcF0", o_addr_pcF, 32'h0);
    chk("wr_instrD", o_data_instrD, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
